// File: rtl/sa32_feeder_pkg.sv
// Shared constants, FSM state type and lane pack/unpack helpers for the
// 32x32 systolic-array operand feeder. Lane 0 occupies the MSBs of a bus.
package sa_pkg;

    localparam int unsigned N         = 32;
    localparam int unsigned WIDTH     = 8;
    localparam int unsigned C_WIDTH   = 32;
    localparam int unsigned KW        = 16;
    localparam int unsigned FLUSH_CYC = 3 * N - 2;
    localparam int unsigned FCW       = $clog2(FLUSH_CYC);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        CTRL
    } feeder_state_e;

    typedef logic [WIDTH-1:0]   lane_t;
    typedef logic [N*WIDTH-1:0] bus_t;

    function automatic lane_t lane_get(input bus_t b, input int unsigned i);
        return b[(N-1-i)*WIDTH +: WIDTH];
    endfunction

    function automatic bus_t lane_set(input bus_t b, input int unsigned i, input lane_t v);
        bus_t r;
        r = b;
        r[(N-1-i)*WIDTH +: WIDTH] = v;
        return r;
    endfunction

endpackage

// File: rtl/sa32_feeder_if.sv
// Operand/control bundle between a job source and the sa32_feeder.
// SA_FEEDER_BUBBLE_CNT_EN adds the bubble_cnt observation signal.
interface sa32_feeder_if;
    import sa_pkg::*;

    logic               start;
    logic [KW-1:0]      k_len;
    logic               in_valid;
    logic               in_ready;
    logic [N*WIDTH-1:0] in_act;
    logic [N*WIDTH-1:0] in_weight;
    logic [N*WIDTH-1:0] activation;
    logic [N*WIDTH-1:0] weight;
    logic               control;
    logic               busy;
    logic               done;
`ifdef SA_FEEDER_BUBBLE_CNT_EN
    logic [KW-1:0]      bubble_cnt;

    modport master (
        output start, k_len, in_valid, in_act, in_weight,
        input  in_ready, activation, weight, control, busy, done, bubble_cnt
    );
    modport slave (
        input  start, k_len, in_valid, in_act, in_weight,
        output in_ready, activation, weight, control, busy, done, bubble_cnt
    );
`else
    modport master (
        output start, k_len, in_valid, in_act, in_weight,
        input  in_ready, activation, weight, control, busy, done
    );
    modport slave (
        input  start, k_len, in_valid, in_act, in_weight,
        output in_ready, activation, weight, control, busy, done
    );
`endif

endinterface

// File: rtl/sa32_feeder_skew_line.sv
// Per-lane delay line: DEPTH=0 is a plain wire, otherwise DEPTH registers
// with asynchronous clear.
module skew_line #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    if (DEPTH == 0) begin : g_wire
        logic w_unused;
        assign w_unused = clk ^ rstn;
        assign o_q      = i_d;
    end else begin : g_reg
        logic [DEPTH-1:0][WIDTH-1:0] r_sr;

        // shift the lane value one stage per clock
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_sr <= '0;
            end else begin
                r_sr[0] <= i_d;
                for (int unsigned k = 1; k < DEPTH; k++) begin
                    r_sr[k] <= r_sr[k-1];
                end
            end
        end

        assign o_q = r_sr[DEPTH-1];
    end

endmodule

// File: rtl/sa32_feeder.sv
// Transmit side of the 32x32 systolic-array operand interface: registers one
// K-step per cycle, skews lane i by i cycles, flushes, then pulses control
// and done. Optional macro SA_FEEDER_BUBBLE_CNT_EN adds bubble_cnt.
module sa32_feeder
    import sa_pkg::*;
(
    input  logic           clk,
    input  logic           rstn,
    sa32_feeder_if.slave   bus
);

    feeder_state_e r_state;
    feeder_state_e w_next;
    logic [KW-1:0] r_klen;
    logic [KW-1:0] r_cnt;
    logic [KW-1:0] w_cnt_inc;
    logic [FCW-1:0] r_fcnt;
    logic          r_done;
    logic          w_in_ready;
    logic          w_control;
    logic          w_beat;
    logic          w_flush_end;
    bus_t          r_inj_act;
    bus_t          r_inj_w;
    bus_t          w_act_bus;
    bus_t          w_w_bus;
    lane_t         w_act_in  [N];
    lane_t         w_act_out [N];
    lane_t         w_w_in    [N];
    lane_t         w_w_out   [N];

    assign w_cnt_inc   = r_cnt + KW'(1);
    assign w_beat      = w_in_ready & bus.in_valid;
    assign w_flush_end = (r_fcnt == FCW'(FLUSH_CYC - 1));

    // state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and Moore outputs
    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_control  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next = (bus.k_len != '0) ? STREAM : CTRL;
                end
            end
            STREAM: begin
                w_in_ready = 1'b1;
                if (bus.in_valid && (w_cnt_inc == r_klen)) begin
                    w_next = FLUSH;
                end
            end
            FLUSH: begin
                if (w_flush_end) begin
                    w_next = CTRL;
                end
            end
            CTRL: begin
                w_control = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // job length latch, beat counter and flush timer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_klen <= '0;
            r_cnt  <= '0;
            r_fcnt <= '0;
        end else begin
            if (r_state == IDLE && bus.start) begin
                r_klen <= bus.k_len;
                r_cnt  <= '0;
            end else if (w_beat) begin
                r_cnt <= w_cnt_inc;
            end
            if (r_state == FLUSH) begin
                r_fcnt <= r_fcnt + FCW'(1);
            end else begin
                r_fcnt <= '0;
            end
        end
    end

    // done follows the control cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == CTRL);
        end
    end

    // inject stage: accepted beats enter, everything else becomes zero lanes
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_inj_act <= '0;
            r_inj_w   <= '0;
        end else begin
            r_inj_act <= w_beat ? bus.in_act    : '0;
            r_inj_w   <= w_beat ? bus.in_weight : '0;
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        assign w_act_in[g] = lane_get(r_inj_act, g);
        assign w_w_in[g]   = lane_get(r_inj_w, g);

        skew_line #(.WIDTH(WIDTH), .DEPTH(g)) u_act_skew (
            .clk  (clk),
            .rstn (rstn),
            .i_d  (w_act_in[g]),
            .o_q  (w_act_out[g])
        );

        skew_line #(.WIDTH(WIDTH), .DEPTH(g)) u_w_skew (
            .clk  (clk),
            .rstn (rstn),
            .i_d  (w_w_in[g]),
            .o_q  (w_w_out[g])
        );
    end

    // repack skewed lanes onto the array buses
    always_comb begin
        w_act_bus = '0;
        w_w_bus   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_act_bus = lane_set(w_act_bus, i, w_act_out[i]);
            w_w_bus   = lane_set(w_w_bus, i, w_w_out[i]);
        end
    end

    assign bus.activation = w_act_bus;
    assign bus.weight     = w_w_bus;
    assign bus.in_ready   = w_in_ready;
    assign bus.control    = w_control;
    assign bus.done       = r_done;
    assign bus.busy       = (r_state != IDLE);

`ifdef SA_FEEDER_BUBBLE_CNT_EN
    logic [KW-1:0] r_bubble;

    // count STREAM cycles without valid input; restart per job
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bubble <= '0;
        end else if (r_state == IDLE && bus.start) begin
            r_bubble <= '0;
        end else if (r_state == STREAM && !bus.in_valid) begin
            r_bubble <= r_bubble + KW'(1);
        end
    end

    assign bus.bubble_cnt = r_bubble;
`endif

endmodule

// File: tb/tb_sa32_feeder.sv
// Scoreboard bench for sa32_feeder: the driver predicts, per absolute cycle,
// each skewed lane value, in_ready, busy, and the control/done cycles; the
// monitor compares every cycle and pops event queues when control/done fire.
module tb_sa32_feeder;
    import sa_pkg::*;

    localparam int TB_FLUSH = 3 * N - 2;
    localparam int BW       = N * WIDTH;
    typedef logic [BW-1:0] wide_t;

    logic clk;
    logic rstn;
    int   cyc;
    int   n_cmp;
    int   n_fail;
    bit   end_req;

    wide_t exp_act_at [int];
    wide_t exp_w_at   [int];
    bit    exp_rdy    [int];
    bit    exp_busy   [int];
    int    ctrl_q [$];
    int    done_q [$];
`ifdef SA_FEEDER_BUBBLE_CNT_EN
    int    bub_cyc_q [$];
    int    bub_val_q [$];
`endif

    sa32_feeder_if bus ();

    sa32_feeder u_dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference helpers ----------------
    function automatic wide_t rnd_bus();
        wide_t r;
        for (int i = 0; i < BW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void put_lane(input int at, input int lane,
                                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] w);
        wide_t t;
        t = exp_act_at.exists(at) ? exp_act_at[at] : '0;
        t[(N-1-lane)*WIDTH +: WIDTH] = a;
        exp_act_at[at] = t;
        t = exp_w_at.exists(at) ? exp_w_at[at] : '0;
        t[(N-1-lane)*WIDTH +: WIDTH] = w;
        exp_w_at[at] = t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_garbage();
        bus.in_valid  = 1'($urandom_range(0, 1));
        bus.in_act    = rnd_bus();
        bus.in_weight = rnd_bus();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive_garbage();
            step();
        end
    endtask

    // mode 0: random valid, 1: always valid, 2: valid pattern 1,0,1,1,0,1,
    // 3: always valid with act lane i = i+1 and weight lane i = 2
    task automatic run_job(input int k, input int mode, input bit flush_start);
        int s, beats, bub, b_last, pi;
        bit v;
        bit [5:0] pat;
        wide_t va, vw;
        pat    = 6'b101101;
        s      = cyc;
        b_last = 0;
        drive_garbage();
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        step();
        bus.start = 1'b0;
        if (k == 0) begin
            exp_busy[s+1] = 1'b1;
            ctrl_q.push_back(s + 1);
            done_q.push_back(s + 2);
`ifdef SA_FEEDER_BUBBLE_CNT_EN
            bub_cyc_q.push_back(s + 2);
            bub_val_q.push_back(0);
`endif
            drive_garbage();
            step();
            return;
        end
        beats = 0;
        bub   = 0;
        pi    = 0;
        while (beats < k) begin
            exp_rdy[cyc]  = 1'b1;
            exp_busy[cyc] = 1'b1;
            va = rnd_bus();
            vw = rnd_bus();
            case (mode)
                1:       v = 1'b1;
                2: begin
                    v = (pi < 6) ? pat[5-pi] : 1'b1;
                    pi++;
                end
                3: begin
                    v = 1'b1;
                    for (int i = 0; i < N; i++) begin
                        va[(N-1-i)*WIDTH +: WIDTH] = WIDTH'(i + 1);
                        vw[(N-1-i)*WIDTH +: WIDTH] = WIDTH'(2);
                    end
                end
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            bus.in_valid  = v;
            bus.in_act    = va;
            bus.in_weight = vw;
            if (v) begin
                for (int i = 0; i < N; i++)
                    put_lane(cyc + 1 + i, i, va[(N-1-i)*WIDTH +: WIDTH], vw[(N-1-i)*WIDTH +: WIDTH]);
                beats++;
                b_last = cyc;
            end else begin
                bub++;
            end
            step();
        end
        ctrl_q.push_back(b_last + 1 + TB_FLUSH);
        done_q.push_back(b_last + 2 + TB_FLUSH);
`ifdef SA_FEEDER_BUBBLE_CNT_EN
        bub_cyc_q.push_back(b_last + 2 + TB_FLUSH);
        bub_val_q.push_back(bub);
`endif
        while (cyc < b_last + 2 + TB_FLUSH) begin
            exp_busy[cyc] = 1'b1;
            drive_garbage();
            bus.start = flush_start && (cyc == b_last + 10);
            bus.k_len = KW'($urandom_range(1, 9));
            step();
        end
        bus.start = 1'b0;
    endtask

    task automatic reset_mid_stream();
        wide_t va, vw;
        bus.start = 1'b1;
        bus.k_len = KW'(8);
        step();
        bus.start = 1'b0;
        for (int j = 0; j < 3; j++) begin
            exp_rdy[cyc]  = 1'b1;
            exp_busy[cyc] = 1'b1;
            va = rnd_bus();
            vw = rnd_bus();
            bus.in_valid  = 1'b1;
            bus.in_act    = va;
            bus.in_weight = vw;
            for (int i = 0; i < N; i++)
                put_lane(cyc + 1 + i, i, va[(N-1-i)*WIDTH +: WIDTH], vw[(N-1-i)*WIDTH +: WIDTH]);
            step();
        end
        bus.in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        exp_act_at.delete();
        exp_w_at.delete();
        exp_rdy.delete();
        exp_busy.delete();
        step();
        step();
        rstn = 1'b1;
        idle(12);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        end_req       = 1'b0;
        rstn          = 1'b1;
        bus.start     = 1'b0;
        bus.k_len     = '0;
        bus.in_valid  = 1'b0;
        bus.in_act    = '0;
        bus.in_weight = '0;
        #2;
        rstn = 1'b0;
        step();
        step();
        rstn = 1'b1;
        idle(3);
        reset_mid_stream();
        run_job(1, 3, 1'b0);
        idle(2);
        run_job(4, 2, 1'b0);
        idle(3);
        run_job(0, 0, 1'b0);
        idle(2);
        run_job(5, 0, 1'b1);
        idle(1);
        run_job(3, 0, 1'b0);
        step();
        run_job(3, 0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            idle($urandom_range(0, 3));
            run_job($urandom_range(1, 20), 0, 1'b0);
        end
        idle(40);
        end_req = 1'b1;
    end

    // ---------------- monitor / scoreboard ----------------
    function automatic void chk(input string nm, input wide_t got, input wide_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: cycle %0d got %h expected %h", nm, cyc, got, exp);
        end
    endfunction

    initial begin
        n_cmp  = 0;
        n_fail = 0;
    end

    always begin
        @(negedge clk or negedge rstn);
        if (!rstn) begin
            #1;
            chk("rst_activation", bus.activation, '0);
            chk("rst_weight", bus.weight, '0);
            chk("rst_control", wide_t'(bus.control), '0);
            chk("rst_done", wide_t'(bus.done), '0);
            chk("rst_busy", wide_t'(bus.busy), '0);
            chk("rst_in_ready", wide_t'(bus.in_ready), '0);
        end else begin
            chk("activation", bus.activation, exp_act_at.exists(cyc) ? exp_act_at[cyc] : '0);
            chk("weight", bus.weight, exp_w_at.exists(cyc) ? exp_w_at[cyc] : '0);
            chk("in_ready", wide_t'(bus.in_ready), wide_t'(exp_rdy.exists(cyc)));
            chk("busy", wide_t'(bus.busy), wide_t'(exp_busy.exists(cyc)));

            if (ctrl_q.size() != 0 && ctrl_q[0] < cyc)
                chk("control_missing", wide_t'(cyc), wide_t'(ctrl_q.pop_front()));
            if (bus.control) begin
                if (ctrl_q.size() == 0) chk("control_unexpected", wide_t'(bus.control), '0);
                else                    chk("control_cycle", wide_t'(cyc), wide_t'(ctrl_q.pop_front()));
            end
            if (done_q.size() != 0 && done_q[0] < cyc)
                chk("done_missing", wide_t'(cyc), wide_t'(done_q.pop_front()));
            if (bus.done) begin
                if (done_q.size() == 0) chk("done_unexpected", wide_t'(bus.done), '0);
                else                    chk("done_cycle", wide_t'(cyc), wide_t'(done_q.pop_front()));
            end
`ifdef SA_FEEDER_BUBBLE_CNT_EN
            if (bub_cyc_q.size() != 0 && bub_cyc_q[0] <= cyc) begin
                void'(bub_cyc_q.pop_front());
                chk("bubble_cnt", wide_t'(bus.bubble_cnt), wide_t'(bub_val_q.pop_front()));
            end
`endif
            if (end_req) begin
                chk("control_outstanding", wide_t'(ctrl_q.size()), '0);
                chk("done_outstanding", wide_t'(done_q.size()), '0);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
            if (cyc > 30000) begin
                n_cmp++;
                n_fail++;
                $display("FAIL watchdog: cycle %0d got no end expected end before 30000", cyc);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
                $finish;
            end
        end
    end

endmodule
